// File: rtl/median_pkg.sv
// Shared types and helpers for the 5x5 median frame controller.
package median_pkg;

  // Default width of the frame geometry inputs and the coordinate outputs.
  localparam int DIM_W_DEFAULT = 13;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Kernel radius: the number of rows/columns on each side of the centre.
  function automatic int kernel_radius(input int k);
    return k / 2;
  endfunction

  // Line-buffer advances needed before the first window is centred on pixel
  // (0,0): R full lines plus R pixels.
  function automatic logic [31:0] step_offset(input int r, input logic [31:0] w);
    return 32'(r) * w + 32'(r);
  endfunction

endpackage

// File: rtl/median_5x5_frame_ctrl_if.sv
// Video stream handshake bundle (valid/ready with start-of-frame and
// end-of-line sideband) used to group the controller's stream signals.
// A beat transfers in any cycle where tvalid and tready are both high;
// tuser and tlast are only meaningful in that cycle.
interface median_5x5_frame_ctrl_if;
  logic tvalid;
  logic tuser;
  logic tlast;
  logic tready;

  modport master (output tvalid, output tuser, output tlast, input  tready);
  modport slave  (input  tvalid, input  tuser, input  tlast, output tready);
endinterface

// File: rtl/median_sideband_delay.sv
// Fixed-depth shift register that aligns the window sideband with the
// median datapath result. Cleared asynchronously so no stale beat survives
// a reset.
module median_sideband_delay #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  // Shift one stage per cycle; every stage clears on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/median_5x5_frame_ctrl.sv
// Frame sequencer for the 5x5 median datapath: accepts the input stream,
// drives line-buffer write/flush strobes, tracks the window centre and
// regenerates the output stream sideband after the datapath latency.
module median_5x5_frame_ctrl
  import median_pkg::*;
#(
  parameter int KERNEL_SIZE = 5,
  parameter int DIM_W       = DIM_W_DEFAULT,
  parameter int PIPE_LAT    = 4
) (
  input  logic             i_clk,
  input  logic             i_areset,
  input  logic [DIM_W-1:0] WIDTH,
  input  logic [DIM_W-1:0] HEIGHT,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             o_lb_wr_en,
  output logic             o_lb_flush,
  output logic             o_win_valid,
  output logic             o_border,
  output logic [DIM_W-1:0] o_col,
  output logic [DIM_W-1:0] o_row,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             o_busy,
  output logic             o_err_sof,
  output logic             o_err_eol,
  output logic             o_err_cfg
);

  localparam int R     = kernel_radius(KERNEL_SIZE);
  // Wide enough for R*W + R with W at its maximum.
  localparam int OFF_W = DIM_W + $clog2(R + 1) + 1;

  localparam logic [DIM_W-1:0] KSZ = DIM_W'(KERNEL_SIZE);
  localparam logic [DIM_W-1:0] RAD = DIM_W'(R);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  // State and frame registers.
  state_e           state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d;
  logic [DIM_W-1:0] h_q, h_d;
  logic [OFF_W-1:0] off_q, off_d;
  // Input raster position of the next accepted beat.
  logic [DIM_W-1:0] in_x_q, in_x_d;
  logic [DIM_W-1:0] in_y_q, in_y_d;
  // Steps taken so far, saturating at the offset: once equal, every step
  // produces a window.
  logic [OFF_W-1:0] fill_q, fill_d;
  // Centre of the next window to be produced.
  logic [DIM_W-1:0] cx_q, cx_d;
  logic [DIM_W-1:0] cy_q, cy_d;

  // Registered window outputs.
  logic             win_valid_q, win_valid_d;
  logic             win_user_q, win_user_d;
  logic             win_last_q, win_last_d;
  logic             border_q, border_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic             err_sof_q, err_sof_d;
  logic             err_eol_q, err_eol_d;
  logic             err_cfg_q, err_cfg_d;

  // Combinational decode.
  logic             ready_c;
  logic             wr_en_c;
  logic             flush_c;
  logic             step_c;
  logic             restart_c;
  logic             geo_ok;
  logic             producing;
  logic             exp_tlast;
  logic             last_in;
  logic             ctr_last;
  logic [OFF_W-1:0] off_new;
  logic [2:0]       sb_out;

  assign geo_ok    = (WIDTH >= KSZ) && (HEIGHT >= KSZ);
  assign off_new   = OFF_W'(step_offset(R, 32'(WIDTH)));
  assign producing = (fill_q == off_q);
  assign exp_tlast = (in_x_q == w_q - ONE);
  assign last_in   = exp_tlast && (in_y_q == h_q - ONE);
  assign ctr_last  = (cx_q == w_q - ONE) && (cy_q == h_q - ONE);

  // Next-state, strobes and next values of every counter and flag.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    off_d       = off_q;
    in_x_d      = in_x_q;
    in_y_d      = in_y_q;
    fill_d      = fill_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    col_d       = col_q;
    row_d       = row_q;
    border_d    = border_q;
    win_valid_d = 1'b0;
    win_user_d  = 1'b0;
    win_last_d  = 1'b0;
    err_sof_d   = 1'b0;
    err_eol_d   = 1'b0;
    err_cfg_d   = 1'b0;
    ready_c     = ~i_areset && (state_q != FLUSH);
    wr_en_c     = 1'b0;
    flush_c     = 1'b0;
    step_c      = 1'b0;
    restart_c   = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a start-of-frame beat opens a frame; anything else is dropped.
        if (s_axis_tvalid && ready_c && s_axis_tuser) begin
          if (geo_ok) begin
            restart_c = 1'b1;
            state_d   = RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (s_axis_tvalid && ready_c) begin
          if (s_axis_tuser) begin
            // Early start of frame: abandon the current frame and restart on
            // this beat. Windows already in the delay line still drain.
            err_sof_d = 1'b1;
            if (geo_ok) begin
              restart_c = 1'b1;
            end else begin
              err_cfg_d = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            wr_en_c   = 1'b1;
            step_c    = 1'b1;
            err_eol_d = s_axis_tlast ^ exp_tlast;
            // Coordinates follow the latched geometry, never tlast.
            if (exp_tlast) begin
              in_x_d = '0;
              in_y_d = last_in ? '0 : in_y_q + ONE;
            end else begin
              in_x_d = in_x_q + ONE;
            end
            if (last_in) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        step_c  = 1'b1;
        if (producing && ctr_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The start-of-frame beat is pixel (0,0) and step 0 of the new frame.
    if (restart_c) begin
      wr_en_c   = 1'b1;
      w_d       = WIDTH;
      h_d       = HEIGHT;
      off_d     = off_new;
      in_x_d    = ONE;
      in_y_d    = '0;
      fill_d    = OFF_W'(1);
      cx_d      = '0;
      cy_d      = '0;
      err_eol_d = s_axis_tlast;
    end

    // Each non-restart step either fills the buffers or produces a window.
    if (step_c) begin
      if (producing) begin
        win_valid_d = 1'b1;
        col_d       = cx_q;
        row_d       = cy_q;
        border_d    = (cx_q < RAD) || (cx_q >= w_q - RAD) ||
                      (cy_q < RAD) || (cy_q >= h_q - RAD);
        win_user_d  = (cx_q == '0) && (cy_q == '0);
        win_last_d  = (cx_q == w_q - ONE);
        if (cx_q == w_q - ONE) begin
          cx_d = '0;
          cy_d = (cy_q == h_q - ONE) ? '0 : cy_q + ONE;
        end else begin
          cx_d = cx_q + ONE;
        end
      end else begin
        fill_d = fill_q + OFF_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Geometry, counters and registered window/error outputs.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      w_q         <= '0;
      h_q         <= '0;
      off_q       <= '0;
      in_x_q      <= '0;
      in_y_q      <= '0;
      fill_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      border_q    <= 1'b0;
      win_valid_q <= 1'b0;
      win_user_q  <= 1'b0;
      win_last_q  <= 1'b0;
      err_sof_q   <= 1'b0;
      err_eol_q   <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else begin
      w_q         <= w_d;
      h_q         <= h_d;
      off_q       <= off_d;
      in_x_q      <= in_x_d;
      in_y_q      <= in_y_d;
      fill_q      <= fill_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      border_q    <= border_d;
      win_valid_q <= win_valid_d;
      win_user_q  <= win_user_d;
      win_last_q  <= win_last_d;
      err_sof_q   <= err_sof_d;
      err_eol_q   <= err_eol_d;
      err_cfg_q   <= err_cfg_d;
    end
  end

  median_sideband_delay #(
    .DEPTH (PIPE_LAT),
    .W     (3)
  ) u_sideband (
    .clk_i (i_clk),
    .rst_i (i_areset),
    .d_i   ({win_valid_q, win_user_q, win_last_q}),
    .q_o   (sb_out)
  );

  assign s_axis_tready = ready_c;
  assign o_lb_wr_en    = wr_en_c;
  assign o_lb_flush    = flush_c;
  assign o_win_valid   = win_valid_q;
  assign o_border      = border_q;
  assign o_col         = col_q;
  assign o_row         = row_q;
  assign o_busy        = (state_q != IDLE);
  assign o_err_sof     = err_sof_q;
  assign o_err_eol     = err_eol_q;
  assign o_err_cfg     = err_cfg_q;
  assign {m_axis_tvalid, m_axis_tuser, m_axis_tlast} = sb_out;

endmodule

// File: tb/tb_median_5x5_frame_ctrl.sv
// Directed bench for the median frame controller: geometry 8x6, kernel 5,
// datapath latency 4.
module tb_median_5x5_frame_ctrl;

  localparam int DW  = 13;
  localparam int LAT = 4;
  localparam int CW  = 1 + 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] width, height;
  logic          lb_wr_en, lb_flush, win_valid, border, busy;
  logic          err_sof, err_eol, err_cfg;
  logic [DW-1:0] col, row;

  median_5x5_frame_ctrl_if in_if();
  median_5x5_frame_ctrl_if out_if();
  assign out_if.tready = 1'b1;

  median_5x5_frame_ctrl #(.KERNEL_SIZE(5), .DIM_W(DW), .PIPE_LAT(LAT)) dut (
    .i_clk         (clk),
    .i_areset      (rst),
    .WIDTH         (width),
    .HEIGHT        (height),
    .s_axis_tvalid (in_if.tvalid),
    .s_axis_tuser  (in_if.tuser),
    .s_axis_tlast  (in_if.tlast),
    .s_axis_tready (in_if.tready),
    .o_lb_wr_en    (lb_wr_en),
    .o_lb_flush    (lb_flush),
    .o_win_valid   (win_valid),
    .o_border      (border),
    .o_col         (col),
    .o_row         (row),
    .m_axis_tvalid (out_if.tvalid),
    .m_axis_tuser  (out_if.tuser),
    .m_axis_tlast  (out_if.tlast),
    .o_busy        (busy),
    .o_err_sof     (err_sof),
    .o_err_eol     (err_eol),
    .o_err_cfg     (err_cfg)
  );

  // ---------------- monitor ----------------
  int cyc = 0, n_wr = 0, n_fl = 0, n_mv = 0, n_mu = 0, n_ml = 0;
  int n_sof = 0, n_eol = 0, n_cfg = 0, n_rdy_fl = 0;
  logic          busy_d = 1'b0;
  logic [CW-1:0] got_q[$];
  int            step_cyc_q[$];
  int            mv_cyc_q[$];
  int            sof_cyc_q[$];
  int            busy_rise_q[$];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    busy_d <= busy;
    if (!rst) begin
      if (lb_wr_en) n_wr <= n_wr + 1;
      if (lb_flush) n_fl <= n_fl + 1;
      if (lb_flush && in_if.tready) n_rdy_fl <= n_rdy_fl + 1;
      if (lb_wr_en || lb_flush) step_cyc_q.push_back(cyc);
      if (lb_wr_en && in_if.tuser) sof_cyc_q.push_back(cyc);
      if (busy && !busy_d) busy_rise_q.push_back(cyc);
      if (win_valid) got_q.push_back({border, row, col});
      if (out_if.tvalid) begin
        n_mv <= n_mv + 1;
        mv_cyc_q.push_back(cyc);
      end
      if (out_if.tuser) n_mu <= n_mu + 1;
      if (out_if.tlast) n_ml <= n_ml + 1;
      if (err_sof) n_sof <= n_sof + 1;
      if (err_eol) n_eol <= n_eol + 1;
      if (err_cfg) n_cfg <= n_cfg + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  function automatic logic [11:0] outs_vec();
    return {in_if.tready, lb_wr_en, lb_flush, win_valid, border, out_if.tvalid,
            out_if.tuser, out_if.tlast, busy, err_sof, err_eol, err_cfg};
  endfunction

  task automatic push_exp(input int w, input int h, input int x, input int y);
    logic          b;
    logic [DW-1:0] xv, yv;
    b  = (x < 2) || (x >= w - 2) || (y < 2) || (y >= h - 2);
    xv = DW'(x);
    yv = DW'(y);
    exp_q.push_back({b, yv, xv});
  endtask

  task automatic build_exp(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) push_exp(w, h, x, y);
  endtask

  int b_wr, b_fl, b_mv, b_mu, b_ml, b_sof, b_eol, b_cfg, b_rdy;
  int b_got, b_step, b_mvc, b_sofc, b_busy;

  task automatic snap();
    b_wr = n_wr;   b_fl = n_fl;   b_mv = n_mv;   b_mu = n_mu;   b_ml = n_ml;
    b_sof = n_sof; b_eol = n_eol; b_cfg = n_cfg; b_rdy = n_rdy_fl;
    b_got = got_q.size();  b_step = step_cyc_q.size(); b_mvc = mv_cyc_q.size();
    b_sofc = sof_cyc_q.size(); b_busy = busy_rise_q.size();
  endtask

  task automatic check_frame(input string tag, input int e_wr, input int e_fl,
                             input int e_bord, input int e_mu, input int e_ml,
                             input int e_sof, input int e_eol, input int e_cfg);
    int nb = 0;
    check({tag, "_wr"},        n_wr - b_wr, e_wr);
    check({tag, "_flush"},     n_fl - b_fl, e_fl);
    check({tag, "_nwin"},      got_q.size() - b_got, exp_q.size());
    check({tag, "_m_tvalid"},  n_mv - b_mv, exp_q.size());
    check({tag, "_m_tuser"},   n_mu - b_mu, e_mu);
    check({tag, "_m_tlast"},   n_ml - b_ml, e_ml);
    check({tag, "_err_sof"},   n_sof - b_sof, e_sof);
    check({tag, "_err_eol"},   n_eol - b_eol, e_eol);
    check({tag, "_err_cfg"},   n_cfg - b_cfg, e_cfg);
    check({tag, "_rdy_flush"}, n_rdy_fl - b_rdy, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b_got + i < got_q.size()) begin
        check($sformatf("%s_win%0d", tag, i), got_q[b_got+i], exp_q[i]);
        if (got_q[b_got+i][CW-1]) nb++;
      end
    end
    check({tag, "_border_cnt"}, nb, e_bord);
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_beat(input logic user, input logic last);
    logic acc;
    int   guard = 0;
    in_if.tvalid = 1'b1;
    in_if.tuser  = user;
    in_if.tlast  = last;
    do begin
      @(negedge clk);
      acc = in_if.tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("beat_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    in_if.tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int w, input int h, input bit gaps, input int n_pix,
                            input int bad_x, input int bad_y);
    int k = 0;
    width  = DW'(w);
    height = DW'(h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n_pix >= 0 && k >= n_pix) return;
        drive_beat(x == 0 && y == 0, (x == w - 1) ^ (x == bad_x && y == bad_y));
        k++;
        if (gaps) idle_cycles($urandom_range(0, 2));
      end
    end
    in_if.tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    in_if.tvalid = 1'b0;
    while (busy && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 1000) check("idle_timeout", guard, 0);
    idle_cycles(LAT + 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.tvalid = 1'b0;
    in_if.tuser  = 1'b0;
    in_if.tlast  = 1'b0;
    width        = DW'(8);
    height       = DW'(6);

    // Reset state, including tready held low while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", outs_vec(), 0);
    check("rst_col_row", {col, row}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_if.tready, 1);
    check("busy_after_rst", busy, 0);
    @(posedge clk); #1;

    // Beats without tuser are dropped while idle.
    snap();
    repeat (3) drive_beat(1'b0, 1'b0);
    idle_cycles(2);
    check("pre_sof_wr", n_wr - b_wr, 0);
    check("pre_sof_flush", n_fl - b_fl, 0);
    check("pre_sof_busy", busy, 0);

    // Frame 1: 8x6, continuous.
    snap();
    build_exp(8, 6);
    send_frame(8, 6, 1'b0, -1, -1, -1);
    wait_idle();
    check("f1_busy_rise", qget(busy_rise_q, b_busy) - qget(sof_cyc_q, b_sofc), 1);
    check("f1_first_result_lat", qget(mv_cyc_q, b_mvc) - qget(step_cyc_q, b_step + 18), 1 + LAT);
    check("f1_flush_follows_last", qget(step_cyc_q, b_step + 48) - qget(step_cyc_q, b_step + 47), 1);
    check_frame("f1", 48, 18, 40, 1, 6, 0, 0, 0);

    // Frame 2: same geometry with random tvalid gaps.
    snap();
    build_exp(8, 6);
    send_frame(8, 6, 1'b1, -1, -1, -1);
    wait_idle();
    check_frame("f2", 48, 18, 40, 1, 6, 0, 0, 0);

    // Frame 3: early tuser at pixel 20. Steps 18 and 19 of the aborted frame
    // already produced windows (0,0) and (1,0); then the new frame in full.
    snap();
    push_exp(8, 6, 0, 0);
    push_exp(8, 6, 1, 0);
    build_exp(8, 6);
    send_frame(8, 6, 1'b0, 20, -1, -1);
    send_frame(8, 6, 1'b0, -1, -1, -1);
    wait_idle();
    check_frame("f3", 68, 18, 42, 2, 6, 1, 0, 0);

    // Frame 4: stray tlast on (5,2); coordinates follow the geometry.
    snap();
    build_exp(8, 6);
    send_frame(8, 6, 1'b0, -1, 5, 2);
    wait_idle();
    check_frame("f4", 48, 18, 40, 1, 6, 0, 1, 0);

    // Bad geometry: W=4, then H=4.
    snap();
    width  = DW'(4);
    height = DW'(6);
    drive_beat(1'b1, 1'b0);
    idle_cycles(2);
    check("cfg_w_busy", busy, 0);
    width  = DW'(8);
    height = DW'(4);
    drive_beat(1'b1, 1'b0);
    idle_cycles(LAT + 3);
    check("cfg_err_cnt", n_cfg - b_cfg, 2);
    check("cfg_wr", n_wr - b_wr, 0);
    check("cfg_flush", n_fl - b_fl, 0);
    check("cfg_win", got_q.size() - b_got, 0);
    check("cfg_busy", busy, 0);

    // Reset in the middle of FLUSH clears everything at once.
    send_frame(8, 6, 1'b0, -1, -1, -1);
    idle_cycles(3);
    check("pre_rst_in_flush", lb_flush, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_flush_outputs", outs_vec(), 0);
    check("rst_flush_col_row", {col, row}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Frame 5: fresh frame after the mid-flush reset.
    snap();
    build_exp(8, 6);
    send_frame(8, 6, 1'b0, -1, -1, -1);
    wait_idle();
    check_frame("f5", 48, 18, 40, 1, 6, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_5x5_frame_ctrl.md
# median_5x5_frame_ctrl

Frame sequencer for the 5x5 median datapath. It sits between the AXI-Stream video input and the line-buffer/sorter pipeline, and tracks pixel coordinates against the runtime frame geometry. It drives line-buffer write and flush strobes, flushes the final kernel-radius rows after end of frame, and regenerates output tvalid/tuser/tlast aligned to the datapath latency. It also flags border windows and protocol errors.

## Interface
Parameters:
- KERNEL_SIZE, 5: odd kernel size; R = KERNEL_SIZE/2.
- DIM_W, 13: width of the geometry inputs and coordinate outputs.
- PIPE_LAT, 4: datapath latency, in cycles, from a step to its median result (≥1).

Ports:
- i_clk  in  1  system clock
- i_areset  in  1  reset, asynchronous, active-high
- WIDTH  in  DIM_W  frame width in pixels; sampled at SOF
- HEIGHT  in  DIM_W  frame height in lines; sampled at SOF
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tuser  in  1  start of frame
- s_axis_tlast  in  1  end of line
- s_axis_tready  out  1  input ready
- o_lb_wr_en  out  1  write the current s_axis_tdata into the line buffers
- o_lb_flush  out  1  advance the line buffers with a zero pixel
- o_win_valid  out  1  window centre is a real pixel
- o_border  out  1  centre lies within R of any edge; datapath passes the centre pixel through
- o_col  out  DIM_W  centre column
- o_row  out  DIM_W  centre row
- m_axis_tvalid  out  1  result valid
- m_axis_tuser  out  1  result start of frame
- m_axis_tlast  out  1  result end of line
- o_busy  out  1  state ≠ IDLE
- o_err_sof  out  1  one-cycle pulse on an early SOF
- o_err_eol  out  1  one-cycle pulse on a tlast mismatch
- o_err_cfg  out  1  one-cycle pulse when SOF is rejected for bad geometry

## Operation
- Step: one line-buffer advance, i.e. an accepted pixel (o_lb_wr_en) or a flush (o_lb_flush). Each frame has exactly W·H + R·W + R steps. Step k ≥ R·W + R produces a window whose centre is pixel k − (R·W + R) in raster order.
- States:
  - IDLE: s_axis_tready=1. Beats without tuser are dropped, with no strobe.
    - tuser beat with W≥KERNEL_SIZE and H≥KERNEL_SIZE: latch W/H, accept the beat as pixel (0,0), go to RUN.
    - tuser beat with bad geometry: pulse o_err_cfg, drop the beat, stay in IDLE.
  - RUN: s_axis_tready=1; every accepted beat is one step. The beat at input (W−1, H−1) moves the FSM to FLUSH.
  - FLUSH: s_axis_tready=0. Issue one o_lb_flush per cycle for R·W + R cycles, then go to IDLE.
- Input coordinates in_x/in_y wrap at W−1. The centre counter advances on each producing step.
- tuser in RUN (early SOF):
  - Pulse o_err_sof.
  - Results already in the PIPE_LAT delay are still emitted.
  - Counters and the step count are cleared, W/H are re-latched, and the beat becomes pixel (0,0) of the new frame.
  - Stay in RUN; the aborted frame produces no further windows.
- tuser in FLUSH: not possible, since tready=0.
- tlast mismatch (tlast on in_x≠W−1, or no tlast on in_x=W−1): pulse o_err_eol. Counters follow the geometry, not tlast.
- o_border = (cx<R) | (cx≥W−R) | (cy<R) | (cy≥H−R).
- Sideband mapping:
  - m_axis_tvalid = o_win_valid delayed PIPE_LAT cycles.
  - tuser marks centre (0,0).
  - tlast marks cx=W−1.

## Timing
- Reset values: state=IDLE; all strobes, flags, errors, m_axis_* and counters = 0; s_axis_tready = 0 during reset and 1 in the first cycle after release.
- s_axis_tready, o_lb_wr_en and o_lb_flush are combinational from state and the input handshake. o_lb_wr_en = tvalid & tready & accept-condition.
- o_win_valid, o_border, o_col, o_row and the error pulses are registered: they appear one cycle after the step.
- m_axis_* follow o_win_valid by exactly PIPE_LAT cycles. No back-pressure is applied on the output.
- The RUN→FLUSH transition occurs in the cycle after the last accepted beat. The first flush step is in that cycle.
- Reset asserted mid-frame clears everything immediately, including the delay line; no partial sideband is emitted.

## Structure
- Package median_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - the R and step-offset localparam functions;
  - the DIM_W default.
- Sub-module median_sideband_delay: a PIPE_LAT-deep shift register carrying {valid, user, last}, with async active-high clear.

## Test plan
- W=8, H=6, continuous tvalid: 48 accepted beats, then 18 flush cycles. Result: 48 m_axis_tvalid pulses, 1 tuser, 6 tlast. First m_axis_tvalid comes 1+PIPE_LAT cycles after the 18th step. o_border is high on 48−8 = 40 of the 48 windows (interior is 4×2 = 8).
- Same frame with random tvalid gaps: identical output count and coordinate sequence. o_col/o_row advance only on steps.
- Beats before the first tuser are dropped: zero strobes until the tuser beat. o_busy rises the next cycle.
- Early tuser at pixel 20 of an 8×6 frame: o_err_sof pulses once. The new frame then completes normally with 48 windows for the new frame only.
- tlast at in_x=5 with W=8: o_err_eol pulses and the coordinates are unchanged.
- W=4: o_err_cfg pulses, the FSM stays in IDLE, and there are no strobes.
- Reset asserted during FLUSH: all outputs are 0 the next cycle, and a fresh frame afterwards produces correct counts.
